// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sequencing controller: FSM state codes and ALU opcodes.
package alu_ctrl_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT      = 4'd1;
  localparam logic [3:0] S_ALU1      = 4'd2;
  localparam logic [3:0] S_MUL_ADD   = 4'd3;
  localparam logic [3:0] S_MUL_SHIFT = 4'd4;
  localparam logic [3:0] S_DIV_SHIFT = 4'd5;
  localparam logic [3:0] S_DIV_SUB   = 4'd6;
  localparam logic [3:0] S_DIV_TEST  = 4'd7;
  localparam logic [3:0] S_FINISH    = 4'd8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    IDLE      = S_IDLE,
    INIT      = S_INIT,
    ALU1      = S_ALU1,
    MUL_ADD   = S_MUL_ADD,
    MUL_SHIFT = S_MUL_SHIFT,
    DIV_SHIFT = S_DIV_SHIFT,
    DIV_SUB   = S_DIV_SUB,
    DIV_TEST  = S_DIV_TEST,
    FINISH    = S_FINISH
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the 8-bit ALU: single-cycle ADD/SUB, shift-and-add MUL,
// restoring DIV. Drives the sibling iteration counter and the A/Q/M register strobes.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int LAST  = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [CNT_W-1:0] CNT_OUT,
  input  logic             Q0,
  input  logic             A_SIGN,
  output logic             CNT,
  output logic             CNT_CLR,
  output logic             LD,
  output logic             ADD_EN,
  output logic             SUB_EN,
  output logic             SHIFT,
  output logic             SHIFT_L,
  output logic             SET_Q0,
  output logic             RESTORE,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

  state_t     state, next;
  logic [1:0] op_r;
  logic       last_iter;

  // The counter advances on the same edge we test it, so LAST here means "this is the 8th pass".
  assign last_iter = (CNT_OUT == LAST_V);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      op_r  <= OP_ADD;
    end else begin
      state <= next;
      if (state == IDLE && START) op_r <= OP;
    end
  end

  always_comb begin
    next    = state;
    CNT     = 1'b0;
    CNT_CLR = 1'b0;
    LD      = 1'b0;
    ADD_EN  = 1'b0;
    SUB_EN  = 1'b0;
    SHIFT   = 1'b0;
    SHIFT_L = 1'b0;
    SET_Q0  = 1'b0;
    RESTORE = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state)
      IDLE: if (START) next = INIT;
      INIT: begin
        LD      = 1'b1;
        CNT_CLR = 1'b1;
        BUSY    = 1'b1;
        case (op_r)
          OP_MUL:  next = MUL_ADD;
          OP_DIV:  next = DIV_SHIFT;
          default: next = ALU1;
        endcase
      end
      ALU1: begin
        ADD_EN = (op_r == OP_ADD);
        SUB_EN = (op_r == OP_SUB);
        BUSY   = 1'b1;
        next   = FINISH;
      end
      MUL_ADD: begin
        ADD_EN = Q0;
        BUSY   = 1'b1;
        next   = MUL_SHIFT;
      end
      MUL_SHIFT: begin
        SHIFT = 1'b1;
        CNT   = 1'b1;
        BUSY  = 1'b1;
        next  = last_iter ? FINISH : MUL_ADD;
      end
      DIV_SHIFT: begin
        SHIFT   = 1'b1;
        SHIFT_L = 1'b1;
        BUSY    = 1'b1;
        next    = DIV_SUB;
      end
      DIV_SUB: begin
        SUB_EN = 1'b1;
        BUSY   = 1'b1;
        next   = DIV_TEST;
      end
      DIV_TEST: begin
        // Negative trial remainder: undo the subtract; otherwise the quotient bit is 1.
        RESTORE = A_SIGN;
        SET_Q0  = ~A_SIGN;
        CNT     = 1'b1;
        BUSY    = 1'b1;
        next    = last_iter ? FINISH : DIV_SHIFT;
      end
      FINISH: begin
        DONE = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: counter/datapath model plus per-operation expectations.
module tb_alu_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [1:0] OP = 2'b00;
  logic [2:0] cnt_m = 3'd0;
  logic       Q0, A_SIGN;
  logic       CNT, CNT_CLR, LD, ADD_EN, SUB_EN, SHIFT, SHIFT_L, SET_Q0, RESTORE, BUSY, DONE;
  logic [7:0] qpat = 8'h00;
  logic [7:0] apat = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;

  alu_seq_ctrl #(.CNT_W(3), .LAST(7)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .CNT_OUT(cnt_m), .Q0(Q0), .A_SIGN(A_SIGN),
    .CNT(CNT), .CNT_CLR(CNT_CLR), .LD(LD), .ADD_EN(ADD_EN), .SUB_EN(SUB_EN), .SHIFT(SHIFT),
    .SHIFT_L(SHIFT_L), .SET_Q0(SET_Q0), .RESTORE(RESTORE), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Sibling 3-bit counter; not touched by RST, only by CNT_CLR.
  always @(posedge CLK) begin
    if (CNT_CLR) cnt_m <= 3'd0;
    else if (CNT) cnt_m <= cnt_m + 3'd1;
  end

  // Datapath flags indexed by the current iteration number.
  assign Q0     = qpat[cnt_m];
  assign A_SIGN = apat[cnt_m];

  function automatic logic [10:0] outs();
    return {CNT, CNT_CLR, LD, ADD_EN, SUB_EN, SHIFT, SHIFT_L, SET_Q0, RESTORE, BUSY, DONE};
  endfunction

  // Issue one operation and compare its whole trace against a per-op summary.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] qp,
                        input logic [7:0] ap);
    int done_cyc = -1, ld_cyc = -1, clr_cyc = -1, alu_cyc = -1;
    int n_ld = 0, n_clr = 0, n_sub = 0, n_shl = 0, n_shr = 0, n_cnt = 0, n_busy = 0, n_done = 0;
    int viol = 0;
    logic [7:0] add_mask = 8'h00, res_mask = 8'h00, setq_mask = 8'h00;
    int e_done, e_sub, e_shl, e_shr, e_cnt, e_alu;
    logic [7:0] e_add, e_res, e_setq;
    // Reference: 1 INIT cycle + per-iteration cost * iterations + 1 FINISH cycle.
    case (op)
      2'b00: begin e_done = 3;  e_add = 8'h01; e_sub = 0; e_shl = 0; e_shr = 0; e_cnt = 0;
                   e_res = 8'h00; e_setq = 8'h00; e_alu = 2; end
      2'b01: begin e_done = 3;  e_add = 8'h00; e_sub = 1; e_shl = 0; e_shr = 0; e_cnt = 0;
                   e_res = 8'h00; e_setq = 8'h00; e_alu = 2; end
      2'b10: begin e_done = 1 + 2*8 + 1; e_add = qp; e_sub = 0; e_shl = 0; e_shr = 8; e_cnt = 8;
                   e_res = 8'h00; e_setq = 8'h00; e_alu = -1; end
      default: begin e_done = 1 + 3*8 + 1; e_add = 8'h00; e_sub = 8; e_shl = 8; e_shr = 0;
                   e_cnt = 8; e_res = ap; e_setq = ~ap; e_alu = -1; end
    endcase
    qpat = qp;
    apat = ap;
    @(negedge CLK);
    START = 1'b1;
    OP = op;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge CLK);
      START = 1'b0;
      OP = 2'($urandom);
      if (LD) begin n_ld++; ld_cyc = c; end
      if (CNT_CLR) begin n_clr++; clr_cyc = c; end
      if (ADD_EN) add_mask[cnt_m] = 1'b1;
      if ((ADD_EN || SUB_EN) && alu_cyc < 0) alu_cyc = c;
      if (SUB_EN) n_sub++;
      if (RESTORE) res_mask[cnt_m] = 1'b1;
      if (SET_Q0) setq_mask[cnt_m] = 1'b1;
      if (SHIFT && SHIFT_L) n_shl++;
      if (SHIFT && !SHIFT_L) n_shr++;
      if (CNT) n_cnt++;
      if (BUSY) n_busy++;
      if (DONE) begin n_done++; done_cyc = c; end
      if ((int'(ADD_EN) + int'(SUB_EN) + int'(RESTORE)) > 1 || (SET_Q0 && RESTORE) || (BUSY && DONE))
        viol++;
    end
    n_tests++; if (done_cyc !== e_done) begin n_fail++;
      $display("FAIL %s done_cycle got %0d exp %0d", tag, done_cyc, e_done); end
    n_tests++; if (n_ld !== 1 || ld_cyc !== 1) begin n_fail++;
      $display("FAIL %s ld got n=%0d cyc=%0d exp n=1 cyc=1", tag, n_ld, ld_cyc); end
    n_tests++; if (n_clr !== 1 || clr_cyc !== 1) begin n_fail++;
      $display("FAIL %s cnt_clr got n=%0d cyc=%0d exp n=1 cyc=1", tag, n_clr, clr_cyc); end
    n_tests++; if (add_mask !== e_add) begin n_fail++;
      $display("FAIL %s add_en iterations got %b exp %b", tag, add_mask, e_add); end
    n_tests++; if (n_sub !== e_sub) begin n_fail++;
      $display("FAIL %s sub_en count got %0d exp %0d", tag, n_sub, e_sub); end
    n_tests++; if (n_shl !== e_shl || n_shr !== e_shr) begin n_fail++;
      $display("FAIL %s shifts got L=%0d R=%0d exp L=%0d R=%0d", tag, n_shl, n_shr, e_shl, e_shr); end
    n_tests++; if (res_mask !== e_res || setq_mask !== e_setq) begin n_fail++;
      $display("FAIL %s restore/set_q0 got %b/%b exp %b/%b", tag, res_mask, setq_mask, e_res, e_setq); end
    n_tests++; if (n_cnt !== e_cnt) begin n_fail++;
      $display("FAIL %s cnt pulses got %0d exp %0d", tag, n_cnt, e_cnt); end
    n_tests++; if (n_busy !== e_done - 1 || n_done !== 1) begin n_fail++;
      $display("FAIL %s busy/done cycles got %0d/%0d exp %0d/1", tag, n_busy, n_done, e_done - 1); end
    n_tests++; if (viol !== 0) begin n_fail++;
      $display("FAIL %s strobe exclusivity violations got %0d exp 0", tag, viol); end
    if (op[1] == 1'b0) begin
      n_tests++; if (alu_cyc !== e_alu) begin n_fail++;
        $display("FAIL %s alu strobe cycle got %0d exp %0d", tag, alu_cyc, e_alu); end
    end
  endtask

  task automatic test_reset();
    START = 1'b1;
    OP = 2'b10;
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      n_tests++; if (outs() !== 11'd0) begin n_fail++;
        $display("FAIL reset outputs got %b exp 0", outs()); end
    end
    RST = 1'b0;
    START = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      n_tests++; if (outs() !== 11'd0) begin n_fail++;
        $display("FAIL idle outputs got %b exp 0", outs()); end
    end
  endtask

  task automatic test_add_sub();
    run_op("add", 2'b00, 8'h00, 8'h00);
    run_op("sub", 2'b01, 8'h00, 8'h00);
  endtask

  task automatic test_mul();
    run_op("mul", 2'b10, 8'b0100_1101, 8'h00);
  endtask

  task automatic test_div();
    run_op("div", 2'b11, 8'h00, 8'b1010_1010);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_op("rand", 2'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_midop();
    qpat = 8'($urandom);
    @(negedge CLK);
    START = 1'b1;
    OP = 2'b10;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      START = (c == 5);
      OP = 2'b00;
      if (c == 6) begin
        n_tests++; if (LD !== 1'b0 || BUSY !== 1'b1) begin n_fail++;
          $display("FAIL midop start_ignored got ld=%b busy=%b exp ld=0 busy=1", LD, BUSY); end
      end
    end
    RST = 1'b1;
    #1;
    n_tests++; if (outs() !== 11'd0) begin n_fail++;
      $display("FAIL midop async_reset got %b exp 0", outs()); end
    @(negedge CLK);
    RST = 1'b0;
    n_tests++; if (outs() !== 11'd0) begin n_fail++;
      $display("FAIL midop after_reset got %b exp 0", outs()); end
    run_op("midop_sub", 2'b01, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    int bad_done = 0, bad_ld = 0, overlap = 0;
    @(negedge CLK);
    START = 1'b1;
    OP = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (DONE !== (c % 4 == 3)) bad_done++;
      if (LD !== (c % 4 == 1)) bad_ld++;
      if (BUSY && DONE) overlap++;
    end
    START = 1'b0;
    n_tests++; if (bad_done !== 0) begin n_fail++;
      $display("FAIL b2b done_pattern mismatched cycles got %0d exp 0", bad_done); end
    n_tests++; if (bad_ld !== 0) begin n_fail++;
      $display("FAIL b2b ld_pattern mismatched cycles got %0d exp 0", bad_ld); end
    n_tests++; if (overlap !== 0) begin n_fail++;
      $display("FAIL b2b busy_done_overlap got %0d exp 0", overlap); end
    repeat (3) @(negedge CLK);
    n_tests++; if (outs() !== 11'd0) begin n_fail++;
      $display("FAIL b2b back_to_idle got %b exp 0", outs()); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_midop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit ALU datapath.
- Sequences single-cycle ADD/SUB, 8-iteration shift-and-add MUL and 8-iteration restoring DIV.
- Drives the count enable and clear of the 3-bit iteration counter (counter3) and consumes its OUT value to detect the last iteration.
- Emits load, add, sub, shift and restore strobes to the A/Q/M register datapath.

Parameters:
- CNT_W, 3: width of the iteration counter value input.
- LAST, 7: counter value that marks the final iteration (8 iterations total).

Ports:
- CLK in 1: rising-edge clock.
- RST in 1: reset, asynchronous, active-high.
- START in 1: 1-cycle request; sampled only in IDLE.
- OP in 2: operation, captured with START. 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- CNT_OUT in CNT_W: current iteration counter value.
- Q0 in 1: LSB of Q register (MUL add decision).
- A_SIGN in 1: MSB of A after trial subtract (DIV restore decision).
- CNT out 1: counter count enable.
- CNT_CLR out 1: counter clear.
- LD out 1: load A<=0 (A<=X for ADD/SUB), Q<=operand, M<=operand.
- ADD_EN out 1: A<=A+M.
- SUB_EN out 1: A<=A-M.
- SHIFT out 1: shift {A,Q}.
- SHIFT_L out 1: shift direction, 1 = left (DIV), 0 = right (MUL).
- SET_Q0 out 1: Q[0]<=1.
- RESTORE out 1: A<=A+M after a failed trial subtract.
- BUSY out 1: operation in progress.
- DONE out 1: 1-cycle completion pulse.

Behaviour:
- State register and OP_r are the only flops. Outputs are combinational from state, plus Q0 or A_SIGN where noted.
- States: IDLE, INIT, ALU1, MUL_ADD, MUL_SHIFT, DIV_SHIFT, DIV_SUB, DIV_TEST, FINISH.
- RST high: state=IDLE and OP_r=00 immediately, asynchronously. Every output is 0 in IDLE.
- IDLE:
  - START=1 → INIT, OP_r<=OP.
  - START=0 → stay.
  - START is ignored in every other state.
- INIT: LD=1, CNT_CLR=1, BUSY=1.
  - Next state: ALU1 if OP_r is 00 or 01; MUL_ADD if 10; DIV_SHIFT if 11.
- ALU1: ADD_EN=(OP_r==00), SUB_EN=(OP_r==01), BUSY=1. Next state FINISH.
- MUL_ADD: ADD_EN=Q0, BUSY=1. Next state MUL_SHIFT.
- MUL_SHIFT: SHIFT=1, SHIFT_L=0, CNT=1, BUSY=1.
  - CNT_OUT==LAST → FINISH; otherwise → MUL_ADD.
- DIV_SHIFT: SHIFT=1, SHIFT_L=1, BUSY=1. Next state DIV_SUB.
- DIV_SUB: SUB_EN=1, BUSY=1. Next state DIV_TEST.
- DIV_TEST: RESTORE=A_SIGN, SET_Q0=~A_SIGN, CNT=1, BUSY=1.
  - CNT_OUT==LAST → FINISH; otherwise → DIV_SHIFT.
- FINISH: DONE=1, BUSY=0. Next state IDLE. A new START is accepted one cycle after DONE.
- Last-iteration test: CNT_OUT is compared in the same cycle CNT is pulsed. The counter wraps LAST→0 on that edge; wrap is expected and harmless.
- Latency, with START in cycle 0:
  - ADD/SUB: DONE in cycle 3.
  - MUL: DONE in cycle 18.
  - DIV: DONE in cycle 26.
- Strobe exclusivity: ADD_EN, SUB_EN and RESTORE are mutually exclusive in every cycle. At most one of SET_Q0 and RESTORE is high.
- Reset mid-operation: returns to IDLE with all outputs 0. The counter is not cleared until the next INIT.
- Invalid state encoding: next state = IDLE.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the state encoding, 4-bit localparams S_IDLE..S_FINISH;
  - OP codes OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
- No sub-module. One flat FSM: a state register block plus one combinational next-state/output block.
- The counter stays a sibling instance at the ALU top level.

Test Plan:
- Reset/idle: RST=1 for 2 cycles with START=1 → every output 0 and state IDLE; after release, START=0 keeps all outputs 0.
- ADD: START=1, OP=00 at cycle 0 → LD and CNT_CLR high at cycle 1; ADD_EN at cycle 2; DONE=1 at cycle 3; BUSY high cycles 1-2.
- MUL: OP=10, bench counter model, Q0 driven 1,0,1,1,0,0,1,0 per iteration → exactly 8 SHIFT pulses with SHIFT_L=0; ADD_EN pulses only in iterations 0, 2, 3, 6; DONE at cycle 18.
- DIV: OP=11, A_SIGN = 1 on odd iterations → 8 DIV_SHIFT pulses with SHIFT_L=1; 8 SUB_EN pulses; RESTORE ×4 and SET_Q0 ×4 alternating; DONE at cycle 26.
- Mid-op: START during MUL (cycle 5) is ignored. RST asserted at cycle 9 → all outputs 0 immediately. New START with OP=01 after release → DONE 3 cycles later.
- Back-to-back: START held high continuously → ADD operations complete every 4 cycles. Each DONE is exactly 1 cycle wide, and BUSY never overlaps DONE.
